// File: rtl/spi_bit_sampler.sv
// rtl/spi_bit_sampler.sv - SPI-style link synchroniser and sample-edge bit front-end
//
// Purpose: brings sck/cs_n/mosi into the clk domain, detects the sampling
// edge of sck, and issues one shift_en pulse per sampled bit to drive a
// downstream serial-to-parallel register (words arrive LSB first).
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   sck_in     asynchronous serial clock
//   cs_n_in    asynchronous chip select, active-low
//   mosi_in    asynchronous serial data
//   shift_en   one-cycle pulse per sampled bit
//   serial_in  sampled data bit, valid while shift_en=1
//   word_done  one-cycle pulse with the WIDTH-th shift_en of a word
//   frame_err  one-cycle pulse when cs_n deasserts with a partial word
//   bit_cnt    bits received in the current word, 0..WIDTH-1

module spi_bit_sampler #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck_in,
  input  logic                     cs_n_in,
  input  logic                     mosi_in,
  output logic                     shift_en,
  output logic                     serial_in,
  output logic                     word_done,
  output logic                     frame_err,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic          EDGE_LVL = (SAMPLE_EDGE != 0);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state;

  // Equal-depth chains keep mosi aligned with the sck edge it belongs to.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sample_edge;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sample_edge = (sck_s != sck_prev) && (sck_s == EDGE_LVL);

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sck_prev  <= sck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_en  <= 1'b0;
      serial_in <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      shift_en  <= 1'b0;
      serial_in <= 1'b0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Edges seen in the same cycle as cs falling are ignored here.
          bit_cnt <= '0;
          if (!cs_s) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            // cs release wins over a coincident edge; that edge is dropped.
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
          end else if (sample_edge) begin
            shift_en  <= 1'b1;
            serial_in <= mosi_s;
            if (bit_cnt == LAST_BIT) begin
              word_done <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
